two_tone_switcher: RTL and testbench
====================================

# two_tone_switcher

Alarm tone generator that alternates between two square-wave tones at a fixed tempo and drives a buzzer pin. It sits inside the alarm timer, downstream of the countdown FSM. The FSM's `alarm_on` drives `enable`; the registered output goes to the active buzzer. All timing is derived from the system clock by integer division fixed at elaboration.

## Interface
- `IN_CLK`, default 50_000_000: system clock frequency in Hz.
- `FREQ1_HZ`, default 1000: tone 1 frequency in Hz.
- `FREQ2_HZ`, default 8000: tone 2 frequency in Hz.
- `TEMPO_HZ`, default 4: tone-switch rate; each tone plays for 1/TEMPO_HZ s.
- `clk`  in  1  system clock, all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  1 = sound on, 0 = output forced low; synchronous to `clk`.
- `BZ1`  out  1  registered buzzer drive.

## Operation
- Derived constants, integer division with truncation:
  - `DIV1 = IN_CLK/(2*FREQ1_HZ)`
  - `DIV2 = IN_CLK/(2*FREQ2_HZ)`
  - `DIVTMP = IN_CLK/TEMPO_HZ`
- Legal parameters need `DIV1`, `DIV2` and `DIVTMP` all ≥ 1. Out-of-range values are an elaboration error (`$error`/generate guard).
- Three independent free-running 32-bit counters, `c1`, `c2` and `ctmp`:
  - Each counts 0 to N-1, where N is its divider.
  - At N-1 the counter returns to 0 and toggles its flag: `s1` for `c1`, `s2` for `c2`, `sel` for `ctmp`.
  - Otherwise the counter increments by 1.
- Resulting periods:
  - `s1` period = 2*`DIV1` clocks; `s2` period = 2*`DIV2` clocks.
  - `sel` holds each value for `DIVTMP` clocks.
- Counters and flags run regardless of `enable`. Enabling does not restart tone phase or tempo.
- Output register, updated every rising edge:
  - `enable`=1: `BZ1` <= (`sel` ? `s2` : `s1`).
  - `enable`=0: `BZ1` <= 0.
- `sel`=0 selects tone 1 and `sel`=1 selects tone 2. Tone 1 plays first after reset.
- No handshake. `enable` is a level and is sampled each cycle.

## Timing
- Reset, asynchronous while `rst`=1: `c1`=`c2`=`ctmp`=0; `s1`=`s2`=`sel`=0; `BZ1`=0.
- Reset asserted mid-tone clears state immediately. Restart is deterministic from tone 1 at phase 0.
- Edges are numbered k=1,2,… counting from the first rising edge after `rst` deasserts. Values after edge k:
  - `s1` = floor(k/`DIV1`) mod 2
  - `s2` = floor(k/`DIV2`) mod 2
  - `sel` = floor(k/`DIVTMP`) mod 2
- `BZ1` after edge k equals the selected flag, or 0, as it stood after edge k-1. This is one cycle of latency relative to flags and `sel`.
- `enable` 1→0: `BZ1`=0 after the next edge. `enable` 0→1: `BZ1` follows the selected flag after the next edge.
- Simultaneous `sel` toggle and flag toggle on the same edge: both take effect; the output mux sees the new values on the following edge.
- `DIV`=1 is legal: that flag toggles every clock.
- Counters never exceed N-1 and never wrap at 32 bits.

## Test plan
Parameters for all scenarios: `IN_CLK`=80, `FREQ1_HZ`=4, `FREQ2_HZ`=20, `TEMPO_HZ`=2. This gives `DIV1`=10, `DIV2`=2, `DIVTMP`=40.

- Reset with `enable`=1, then release `rst` → `BZ1`=0 after edges 1–10; 1 after edges 11–20; 0 after 21–30; 1 after 31–40.
- Continue the previous run → `sel`=1 after edge 40. `BZ1` after edges 41,42 = 0,0, then 1,1 after 43,44, then alternating 2-high/2-low through edge 80. Tone 1 resumes from edge 81.
- `enable` held 0 for 200 edges → `BZ1` stays 0. Internal `sel` still toggles at edges 40, 80, 120, 160, 200.
- `enable` raised just before edge 15 (released from reset with `enable`=0) → `BZ1`=1 after edge 15, since `s1`=1 after edge 14. No phase restart.
- Assert `rst` asynchronously between edges 55 and 56 with `enable`=1 → `BZ1`, `sel` and flags go to 0 without a clock edge. After release, the sequence matches scenario 1 exactly.
- Default parameters (50 MHz) → `BZ1` period 50_000 clocks during tone 1 and 6_250 clocks during tone 2. Each tone segment lasts 12_500_000 clocks.

Source files
------------

// File: rtl/two_tone_switcher.sv
// Two-tone alarm buzzer: alternates between two square-wave tones at a fixed tempo.
// All periods come from integer division of the system clock, fixed at elaboration.

module tone_divider #(
    parameter int unsigned DIV = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic flag_o
);

    localparam int unsigned CW = 32;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          flag_q, flag_d;

    // Count 0..DIV-1; the flag toggles on the wrap back to zero.
    always_comb begin
        cnt_d  = cnt_q + CW'(1);
        flag_d = flag_q;
        if (cnt_q == LAST) begin
            cnt_d  = '0;
            flag_d = ~flag_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign flag_o = flag_q;

endmodule

module two_tone_switcher #(
    parameter int unsigned IN_CLK   = 50_000_000,
    parameter int unsigned FREQ1_HZ = 1000,
    parameter int unsigned FREQ2_HZ = 8000,
    parameter int unsigned TEMPO_HZ = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic BZ1
);

    localparam int unsigned DIV1   = (FREQ1_HZ == 0) ? 0 : IN_CLK / (2 * FREQ1_HZ);
    localparam int unsigned DIV2   = (FREQ2_HZ == 0) ? 0 : IN_CLK / (2 * FREQ2_HZ);
    localparam int unsigned DIVTMP = (TEMPO_HZ == 0) ? 0 : IN_CLK / TEMPO_HZ;

    if (DIV1 < 1 || DIV2 < 1 || DIVTMP < 1) begin : g_bad_params
        $error("two_tone_switcher: every divider must be at least 1");
    end

    logic s1;
    logic s2;
    logic sel;
    logic bz1_q, bz1_d;

    tone_divider #(.DIV(DIV1)) u_tone1 (
        .clk_i  (clk),
        .rst_i  (rst),
        .flag_o (s1)
    );

    tone_divider #(.DIV(DIV2)) u_tone2 (
        .clk_i  (clk),
        .rst_i  (rst),
        .flag_o (s2)
    );

    tone_divider #(.DIV(DIVTMP)) u_tempo (
        .clk_i  (clk),
        .rst_i  (rst),
        .flag_o (sel)
    );

    // Tone phase and tempo keep running while muted; enable only gates the output.
    always_comb begin
        bz1_d = 1'b0;
        if (enable) begin
            bz1_d = sel ? s2 : s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bz1_q <= 1'b0;
        end else begin
            bz1_q <= bz1_d;
        end
    end

    assign BZ1 = bz1_q;

endmodule

// File: tb/tb_two_tone_switcher.sv
// Bench for two_tone_switcher: fixed vectors, hand sequences and randomized enable/reset
// against an arithmetic model of flags and output as functions of edges since reset.

module tb_two_tone_switcher;

    localparam int unsigned D1  = 10;
    localparam int unsigned D2  = 2;
    localparam int unsigned DT  = 40;
    localparam int unsigned D1B = 1;
    localparam int unsigned D2B = 2;
    localparam int unsigned DTB = 4;

    typedef struct {
        int unsigned k;
        logic        en;
        logic        exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b1;
    logic bz_a;
    logic bz_b;

    int unsigned k = 0;
    int errors = 0;
    int checks = 0;

    vec_t tbl [17];

    two_tone_switcher #(
        .IN_CLK(80), .FREQ1_HZ(4), .FREQ2_HZ(20), .TEMPO_HZ(2)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .BZ1(bz_a)
    );

    two_tone_switcher #(
        .IN_CLK(8), .FREQ1_HZ(4), .FREQ2_HZ(2), .TEMPO_HZ(2)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .BZ1(bz_b)
    );

    always #5 clk = ~clk;

    // Flag value after edge j for a divider d.
    function automatic logic flag_at(input int unsigned j, input int unsigned d);
        return 1'((j / d) % 2);
    endfunction

    function automatic logic mux_at(input int unsigned j, input int unsigned d1,
                                    input int unsigned d2, input int unsigned dt);
        return flag_at(j, dt) ? flag_at(j, d2) : flag_at(j, d1);
    endfunction

    function automatic logic bz_at(input int unsigned kk, input logic en, input int unsigned d1,
                                   input int unsigned d2, input int unsigned dt);
        if (!en || kk == 0) return 1'b0;
        return mux_at(kk - 1, d1, d2, dt);
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %b want %b", name, k, act, exp);
        end
    endtask

    task automatic tick(input logic en);
        enable = en;
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic check_edge();
        check("bz_a", bz_a, bz_at(k, enable, D1, D2, DT));
        check("bz_b", bz_b, bz_at(k, enable, D1B, D2B, DTB));
        check("sel_a", dut.sel, flag_at(k, DT));
        check("s1_b_div1", dut_b.s1, flag_at(k, D1B));
    endtask

    // Called at posedge+1; asserts reset mid-cycle and checks it acts without an edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_bz_a", bz_a, 1'b0);
        check("rst_bz_b", bz_b, 1'b0);
        check("rst_sel", dut.sel, 1'b0);
        check("rst_s1", dut.s1, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        k = 0;
    endtask

    task automatic run_table();
        for (int i = 0; i < 17; i++) begin
            while (k < tbl[i].k) tick(tbl[i].en);
            check("tbl", bz_a, tbl[i].exp);
        end
    endtask

    initial begin
        tbl[0]  = '{1,  1'b1, 1'b0};
        tbl[1]  = '{10, 1'b1, 1'b0};
        tbl[2]  = '{11, 1'b1, 1'b1};
        tbl[3]  = '{20, 1'b1, 1'b1};
        tbl[4]  = '{21, 1'b1, 1'b0};
        tbl[5]  = '{30, 1'b1, 1'b0};
        tbl[6]  = '{31, 1'b1, 1'b1};
        tbl[7]  = '{40, 1'b1, 1'b1};
        tbl[8]  = '{41, 1'b1, 1'b0};
        tbl[9]  = '{42, 1'b1, 1'b0};
        tbl[10] = '{43, 1'b1, 1'b1};
        tbl[11] = '{44, 1'b1, 1'b1};
        tbl[12] = '{45, 1'b1, 1'b0};
        tbl[13] = '{80, 1'b1, 1'b1};
        tbl[14] = '{81, 1'b1, 1'b0};
        tbl[15] = '{90, 1'b1, 1'b0};
        tbl[16] = '{91, 1'b1, 1'b1};

        // Power-up reset with enable high.
        #2;
        check("por_bz_a", bz_a, 1'b0);
        check("por_sel", dut.sel, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        k = 0;
        run_table();

        // Async reset between edges 55 and 56, then an identical replay.
        do_reset();
        while (k < 55) begin
            tick(1'b1);
            check_edge();
        end
        check("pre_rst_bz", bz_a, 1'b1);
        do_reset();
        run_table();

        // Muted for 200 edges: output stays low, tempo keeps toggling.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            tick(1'b0);
            check_edge();
            if (k % DT == 0) check("mute_sel_toggle", dut.sel, flag_at(k, DT));
        end
        check("mute_bz", bz_a, 1'b0);

        // Enable raised just before edge 15: no phase restart.
        do_reset();
        for (int i = 0; i < 14; i++) tick(1'b0);
        check("pre_en_bz", bz_a, 1'b0);
        tick(1'b1);
        check("en_edge15", bz_a, 1'b1);
        check_edge();
        tick(1'b0);
        check("dis_bz", bz_a, 1'b0);

        // Randomized enable runs with occasional asynchronous resets.
        do_reset();
        begin
            logic en_r;
            en_r = 1'b1;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 15) == 0) en_r = ~en_r;
                if ($urandom_range(0, 599) == 0) do_reset();
                tick(en_r);
                check_edge();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
